// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle ALU.
package alu_pkg;

  // Operation codes produced by the ALU decoder.
  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_LUI  = 4'b1000,
    ALU_XOR  = 4'b1001,
    ALU_BLEZ = 4'b1010,
    ALU_SRLV = 4'b1011,
    ALU_SRL  = 4'b1100
  } alu_op_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  // Serial shift direction.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_t;

  localparam int unsigned LUI_SHIFT = 16;

  // True for the codes that go through the serial shifter.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRLV);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial shifter: one bit position per cycle, counting down the remaining amount.
module alu_serial_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value_i,
  input  logic [SHW-1:0]   amount,
  input  shift_dir_t       direction,
  output logic [WIDTH-1:0] value_o,
  output logic             last,
  output logic             busy
);

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  shift_dir_t       dir_q, dir_d;
  logic [WIDTH-1:0] shifted;

  // Value after this cycle's single-bit shift; the parent latches it on the last step.
  assign shifted = (dir_q == DIR_RIGHT) ? (sreg_q >> 1) : (sreg_q << 1);
  assign value_o = shifted;
  assign last    = (cnt_q == SHW'(1));
  assign busy    = (cnt_q != '0);

  // Load a new operand or advance one step while the counter is non-zero.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    if (load) begin
      sreg_d = value_i;
      cnt_d  = amount;
      dir_d  = direction;
    end else if (cnt_q != '0) begin
      sreg_d = shifted;
      cnt_d  = cnt_q - SHW'(1);
    end
  end

  // Shift register, counter and direction state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      dir_q  <= DIR_LEFT;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic, serial variable shifts,
// start/busy/done handshake toward a non-pipelined controller.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             bad_op
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             bad_op;
  } alu_out_t;

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             bad_op_q, bad_op_d;

  logic             sh_load;
  logic [SHW-1:0]   sh_amount;
  shift_dir_t       sh_dir;
  logic [WIDTH-1:0] sh_value;
  logic             sh_last;
  logic             sh_busy;
  alu_out_t         comb_out;

  // Single-cycle evaluation; shift codes land here only when the amount is zero.
  function automatic alu_out_t compute(input logic [3:0] op, input logic [WIDTH-1:0] a_i,
                                       input logic [WIDTH-1:0] b_i, input logic [SHW-1:0] n);
    alu_out_t o;
    logic     le0;
    le0      = ($signed(a_i) <= $signed({WIDTH{1'b0}}));
    o.bad_op = 1'b0;
    o.result = '0;
    case (op)
      ALU_AND:  o.result = a_i & b_i;
      ALU_OR:   o.result = a_i | b_i;
      ALU_ADD:  o.result = a_i + b_i;
      ALU_SUB:  o.result = a_i - b_i;
      ALU_SLT:  o.result = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_LUI:  o.result = b_i << LUI_SHIFT;
      ALU_XOR:  o.result = a_i ^ b_i;
      ALU_BLEZ: o.result = {{(WIDTH-1){1'b0}}, le0};
      ALU_SLL:  o.result = b_i << n;
      ALU_SRL,
      ALU_SRLV: o.result = b_i >> n;
      default: begin
        o.result = '0;
        o.bad_op = 1'b1;
      end
    endcase
    if (op == ALU_BLEZ) o.zero = le0;
    else                o.zero = (o.result == '0);
    return o;
  endfunction

  // Shift amount and direction decoded from the incoming code.
  always_comb begin
    sh_amount = (alucontrol == ALU_SRLV) ? a[SHW-1:0] : shamt;
    sh_dir    = (alucontrol == ALU_SLL) ? DIR_LEFT : DIR_RIGHT;
    comb_out  = compute(alucontrol, a, b, sh_amount);
  end

  alu_serial_shifter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (sh_load),
    .value_i  (b),
    .amount   (sh_amount),
    .direction(sh_dir),
    .value_o  (sh_value),
    .last     (sh_last),
    .busy     (sh_busy)
  );

  // Next-state and result-capture logic; outputs only move at done-producing edges.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    bad_op_d = bad_op_q;
    sh_load  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (is_shift_op(alucontrol) && (sh_amount != '0)) begin
            sh_load = 1'b1;
            state_d = SHIFT;
          end else begin
            result_d = comb_out.result;
            zero_d   = comb_out.zero;
            bad_op_d = comb_out.bad_op;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        if (sh_last) begin
          result_d = sh_value;
          zero_d   = (sh_value == '0);
          bad_op_d = 1'b0;
          state_d  = DONE;
        end else if (!sh_busy) begin
          // Shifter lost its count without finishing; drop back rather than hang.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      bad_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      bad_op_q <= bad_op_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign zero   = zero_q;
  assign bad_op = bad_op_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu against a behavioural reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alucontrol = 4'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero, bad_op;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .zero(zero), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: outcome and latency from the operation's definition.
  task automatic model(input logic [3:0] op, input logic [31:0] ma, input logic [31:0] mb,
                       input logic [4:0] msh, output logic [31:0] r, output logic z,
                       output logic bad, output int lat);
    int n;
    bad = 1'b0;
    lat = 1;
    n   = 0;
    r   = 0;
    case (op)
      4'b0000: r = ma & mb;
      4'b0001: r = ma | mb;
      4'b0010: r = ma + mb;
      4'b0110: r = ma - mb;
      4'b0111: r = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
      4'b1000: r = mb * 32'h10000;
      4'b1001: r = ma ^ mb;
      4'b1010: r = ($signed(ma) <= 0) ? 32'd1 : 32'd0;
      4'b0011: begin n = int'(msh); r = mb << n; end
      4'b1100: begin n = int'(msh); r = mb >> n; end
      4'b1011: begin n = int'(ma % 32); r = mb >> n; end
      default: begin r = 0; bad = 1'b1; end
    endcase
    if (n > 0) lat = n + 1;
    z = (op == 4'b1010) ? ($signed(ma) <= 0) : (r == 0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] ish);
    alucontrol = op; a = ia; b = ib; shamt = ish; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; shamt = 5'($urandom); alucontrol = 4'($urandom);
  endtask

  // Waits (bounded) for done; lat=0 means it never came.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin lat = c; break; end
      if (busy) bc++;
      tick();
    end
  endtask

  // Issue, wait, compare to model.
  task automatic run_check(input string name, input logic [3:0] op, input logic [31:0] ia,
                           input logic [31:0] ib, input logic [4:0] ish);
    logic [31:0] er; logic ez, eb; int el, lat, bc;
    model(op, ia, ib, ish, er, ez, eb, el);
    issue(op, ia, ib, ish);
    wait_done(lat, bc);
    n_checks++;
    if (lat !== el || result !== er || zero !== ez || bad_op !== eb || bc !== el - 1) begin
      n_fail++;
      $display("FAIL %s op=%b: lat=%0d busy=%0d res=%h z=%b bad=%b, want lat=%0d busy=%0d res=%h z=%b bad=%b",
               name, op, lat, bc, result, zero, bad_op, el, el - 1, er, ez, eb);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; alucontrol = 4'b0010; a = 32'd3; b = 32'd4;
    tick(); tick();
    n_checks++;
    if ({busy, done, zero, bad_op} !== 4'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b res=%h z=%b bad=%b, want all 0", busy, done, result, zero, bad_op);
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release: done=%b res=%h, want 0/0", done, result);
    end
  endtask

  task automatic test_arith();
    run_check("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 5'd0);
    n_checks++;
    if (result !== 32'h80000000 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_const: res=%h z=%b, want 80000000/0", result, zero);
    end
    run_check("sub_zero", 4'b0110, 32'd5, 32'd5, 5'd0);
    n_checks++;
    if (result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_const: res=%h z=%b, want 0/1", result, zero);
    end
    run_check("lui", 4'b1000, 32'h0, 32'h0000ABCD, 5'd0);
    run_check("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    run_check("or",  4'b0001, 32'h12340000, 32'h00005678, 5'd0);
    run_check("xor", 4'b1001, 32'hAAAA5555, 32'hAAAA5555, 5'd0);
  endtask

  task automatic test_slt_blez();
    run_check("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h1, 5'd0);
    n_checks++;
    if (result !== 32'h1) begin
      n_fail++;
      $display("FAIL slt_const: res=%h, want 00000001", result);
    end
    run_check("blez_0",   4'b1010, 32'h0, 32'h0, 5'd0);
    n_checks++;
    if (zero !== 1'b1) begin
      n_fail++;
      $display("FAIL blez0_const: z=%b, want 1", zero);
    end
    run_check("blez_3",   4'b1010, 32'd3, 32'h0, 5'd0);
    n_checks++;
    if (zero !== 1'b0) begin
      n_fail++;
      $display("FAIL blez3_const: z=%b, want 0", zero);
    end
    run_check("blez_neg", 4'b1010, 32'h80000000, 32'h0, 5'd0);
  endtask

  task automatic test_shifts();
    run_check("sll31", 4'b0011, 32'h0, 32'h1, 5'd31);
    n_checks++;
    if (result !== 32'h80000000) begin
      n_fail++;
      $display("FAIL sll31_const: res=%h, want 80000000", result);
    end
    run_check("srlv4", 4'b1011, 32'd4, 32'hF0, 5'd0);
    n_checks++;
    if (result !== 32'h0F) begin
      n_fail++;
      $display("FAIL srlv4_const: res=%h, want 0000000f", result);
    end
    run_check("srl0",  4'b1100, 32'h0, 32'hDEADBEEF, 5'd0);
    run_check("srl_to_zero", 4'b1100, 32'h0, 32'h00000010, 5'd5);
    run_check("srlv_hi_bits", 4'b1011, 32'hFFFFFFE3, 32'h80000000, 5'd0);
  endtask

  task automatic test_start_during_shift();
    int lat, bc;
    issue(4'b0011, 32'h0, 32'h1, 5'd10);
    tick(); tick();
    alucontrol = 4'b0010; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc);
    n_checks++;
    if (lat + 3 !== 11 || result !== 32'h400) begin
      n_fail++;
      $display("FAIL start_in_shift: lat=%0d res=%h, want 11/00000400", lat + 3, result);
    end
    tick();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_not_queued: done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_check("b2b_first", 4'b0010, 32'd10, 32'd20, 5'd0);
    alucontrol = 4'b0010; a = 32'd100; b = 32'd23; start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1 || result !== 32'd123) begin
      n_fail++;
      $display("FAIL back_to_back: done=%b res=%h, want 1/0000007b", done, result);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single_pulse: done=%b, want 0", done);
    end
  endtask

  task automatic test_bad_op();
    run_check("bad_1111", 4'b1111, 32'h1234, 32'h5678, 5'd3);
    n_checks++;
    if (bad_op !== 1'b1 || result !== 32'h0 || zero !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_op_const: bad=%b res=%h z=%b, want 1/0/1", bad_op, result, zero);
    end
    run_check("bad_clears", 4'b0001, 32'h1, 32'h2, 5'd0);
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    issue(4'b1100, 32'h0, 32'hFFFFFFFF, 5'd19);
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_checks++;
    if ({busy, done, zero, bad_op} !== 4'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: busy=%b done=%b res=%h z=%b bad=%b, want all 0", busy, done, result, zero, bad_op);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || busy) seen++;
      tick();
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abandoned_op: busy/done cycles=%0d, want 0", seen);
    end
    run_check("add_after_reset", 4'b0010, 32'd7, 32'd8, 5'd0);
  endtask

  task automatic test_random();
    logic [3:0] codes [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000,
                               4'b1001, 4'b1010, 4'b0011, 4'b1100, 4'b1011, 4'b1101};
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      op = codes[$urandom_range(0, 11)];
      run_check("random", op, $urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
                5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_slt_blez();
    test_shifts();
    test_start_during_shift();
    test_back_to_back();
    test_bad_op();
    test_reset_mid_shift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
